// File: rtl/rng_bank_pkg.sv
// Shared constants for the Avalon-MM LFSR random-number bank.
// Holds the register map, the CTRL bit positions and the default polynomial and seed.
package rng_bank_pkg;

  localparam int REG_CTRL    = 0;
  localparam int REG_STEP    = 1;
  localparam int REG_CH_BASE = 2;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_RD_ADV = 1;
  localparam int CTRL_CLR    = 2;

  // x^32 + x^30 + x^26 + x^25 + 1, right-shift Galois form
  localparam logic [31:0] DEF_TAPS      = 32'hA300_0000;
  localparam logic [31:0] DEF_SEED_BASE = 32'hACE1_ACE1;

endpackage

// File: rtl/rng_lfsr_channel.sv
// One right-shift Galois LFSR channel with a seed load and a single-step enable.
// The state never becomes all-zero: a zero seed (reset or load) is replaced by 1.
module rng_lfsr_channel #(
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] TAPS   = DATA_W'(32'hA300_0000),
  parameter logic [DATA_W-1:0] SEED   = DATA_W'(32'hACE1_ACE1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] state
);

  localparam logic [DATA_W-1:0] ONE       = DATA_W'(1);
  localparam logic [DATA_W-1:0] SEED_SAFE = (SEED == '0) ? ONE : SEED;

  function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] s);
    return (s >> 1) ^ (s[0] ? TAPS : '0);
  endfunction

  function automatic logic [DATA_W-1:0] seed_fix(input logic [DATA_W-1:0] s);
    return (s == '0) ? ONE : s;
  endfunction

  // A bus seed write overrides any step requested in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= SEED_SAFE;
    else if (load)
      state <= seed_fix(load_data);
    else if (step)
      state <= lfsr_next(state);
  end

endmodule

// File: rtl/final_project_platform_rng_bank.sv
// Avalon-MM slave with NUM_CH independent Galois LFSR channels, exported on out_port.
// Zero-wait reads: readdata is the pre-step value; any step lands on the same clock edge.
module final_project_platform_rng_bank
  import rng_bank_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          NUM_CH    = 4,
  parameter int          ADDR_W    = 4,
  parameter logic [31:0] TAPS      = DEF_TAPS,
  parameter logic [31:0] SEED_BASE = DEF_SEED_BASE
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [ADDR_W-1:0]        address,
  input  logic                     chipselect,
  input  logic                     write_n,
  input  logic                     read_n,
  input  logic [DATA_W-1:0]        writedata,
  output logic [DATA_W-1:0]        readdata,
  output logic [NUM_CH*DATA_W-1:0] out_port
);

  logic              ctrl_run;
  logic              ctrl_rd_adv;
  logic [DATA_W-1:0] count;
  logic [DATA_W-1:0] ch_state [NUM_CH];

  logic wr_en;
  logic rd_en;
  logic ctrl_wr;
  logic step_wr;
  logic clr_wr;
  logic global_step;

  // A simultaneous write suppresses the read side effect.
  assign wr_en       = chipselect & ~write_n;
  assign rd_en       = chipselect & ~read_n & write_n;
  assign ctrl_wr     = wr_en && (address == ADDR_W'(REG_CTRL));
  assign step_wr     = wr_en && (address == ADDR_W'(REG_STEP));
  assign clr_wr      = ctrl_wr & writedata[CTRL_CLR];
  assign global_step = ctrl_run | step_wr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_run    <= 1'b0;
      ctrl_rd_adv <= 1'b0;
    end else if (ctrl_wr) begin
      ctrl_run    <= writedata[CTRL_RUN];
      ctrl_rd_adv <= writedata[CTRL_RD_ADV];
    end
  end

  // CLR wins over a concurrent global step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      count <= '0;
    else if (clr_wr)
      count <= '0;
    else if (global_step)
      count <= count + DATA_W'(1);
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    localparam logic [31:0] SEED_K = SEED_BASE + 32'(k);

    logic sel;
    logic ch_load;
    logic ch_step;

    assign sel     = (address == ADDR_W'(REG_CH_BASE + k));
    assign ch_load = wr_en & sel;
    assign ch_step = global_step | (ctrl_rd_adv & rd_en & sel);

    rng_lfsr_channel #(
      .DATA_W (DATA_W),
      .TAPS   (TAPS[DATA_W-1:0]),
      .SEED   (SEED_K[DATA_W-1:0])
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (ch_load),
      .step      (ch_step),
      .load_data (writedata),
      .state     (ch_state[k])
    );

    assign out_port[k*DATA_W +: DATA_W] = ch_state[k];
  end

  always_comb begin
    readdata = '0;
    if (address == ADDR_W'(REG_CTRL)) begin
      readdata[CTRL_RUN]    = ctrl_run;
      readdata[CTRL_RD_ADV] = ctrl_rd_adv;
    end else if (address == ADDR_W'(REG_STEP)) begin
      readdata = count;
    end else begin
      for (int k = 0; k < NUM_CH; k++)
        if (address == ADDR_W'(REG_CH_BASE + k))
          readdata = ch_state[k];
    end
  end

endmodule

// File: tb/tb_final_project_platform_rng_bank.sv
// Directed bench for the LFSR bank: reset seeds, STEP, zero-seed fix, RUN, read-advance, async reset.
`timescale 1ns/1ps
module tb_final_project_platform_rng_bank;

  localparam int DATA_W = 32;
  localparam int NUM_CH = 4;
  localparam int ADDR_W = 4;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [ADDR_W-1:0]        address;
  logic                     chipselect;
  logic                     write_n;
  logic                     read_n;
  logic [DATA_W-1:0]        writedata;
  logic [DATA_W-1:0]        readdata;
  logic [NUM_CH*DATA_W-1:0] out_port;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_ch [NUM_CH];
  logic [31:0] rd;

  final_project_platform_rng_bank #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .read_n     (read_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? 32'hA300_0000 : 32'h0);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [ADDR_W-1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_read(input logic [ADDR_W-1:0] a, output logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; read_n = 1'b0; address = a;
    #1 d = readdata;
    @(posedge clk);
    #1;
    chipselect = 1'b0; read_n = 1'b1;
  endtask

  function automatic logic [31:0] port_ch(input int k);
    return out_port[k*DATA_W +: DATA_W];
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < NUM_CH; k++) exp_ch[k] = 32'hACE1_ACE1 + 32'(k);
  endtask

  initial begin
    reset_n = 1'b0; address = '0; chipselect = 1'b0;
    write_n = 1'b1; read_n = 1'b1; writedata = '0;
    apply_reset();

    // reset values
    bus_read(4'd2, rd); check("rst_ch0", rd, 32'hACE1_ACE1);
    bus_read(4'd3, rd); check("rst_ch1", rd, 32'hACE1_ACE2);
    bus_read(4'd0, rd); check("rst_ctrl", rd, 32'h0);
    bus_read(4'd1, rd); check("rst_count", rd, 32'h0);
    bus_read(4'd7, rd); check("rst_invalid", rd, 32'h0);
    check("rst_port0", port_ch(0), 32'hACE1_ACE1);
    check("rst_port3", port_ch(3), 32'hACE1_ACE4);

    // single STEP write
    bus_write(4'd1, 32'hDEAD_BEEF);
    bus_read(4'd2, rd); check("step_ch0", rd, 32'hF570_D670);
    bus_read(4'd3, rd); check("step_ch1", rd, 32'h5670_D671);
    bus_read(4'd1, rd); check("step_count", rd, 32'd1);
    check("step_port2", port_ch(2), 32'hF570_D671);
    check("step_port3", port_ch(3), 32'h5670_D672);

    // zero seed becomes 1, then steps to the tap mask
    bus_write(4'd4, 32'h0);
    bus_read(4'd4, rd); check("zero_seed", rd, 32'h1);
    bus_write(4'd1, 32'h0);
    bus_read(4'd4, rd); check("zero_step", rd, 32'hA300_0000);
    exp_ch[0] = 32'hF570_D670; exp_ch[1] = 32'h5670_D671;
    exp_ch[2] = 32'hA300_0000; exp_ch[3] = 32'h5670_D672;
    check("port_ch3_after2", port_ch(3), ref_step(32'h5670_D672));
    exp_ch[3] = ref_step(32'h5670_D672);
    exp_ch[0] = ref_step(32'hF570_D670);
    exp_ch[1] = ref_step(32'h5670_D671);

    // CLR, then RUN for exactly ten cycles
    bus_write(4'd0, 32'h4);
    bus_read(4'd1, rd); check("clr_count", rd, 32'h0);
    bus_read(4'd0, rd); check("clr_ctrl", rd, 32'h0);
    bus_write(4'd0, 32'h1);
    repeat (9) @(posedge clk);
    bus_write(4'd0, 32'h0);
    for (int n = 0; n < 10; n++)
      for (int k = 0; k < NUM_CH; k++) exp_ch[k] = ref_step(exp_ch[k]);
    bus_read(4'd1, rd); check("run_count", rd, 32'd10);
    for (int k = 0; k < NUM_CH; k++) begin
      bus_read(ADDR_W'(2 + k), rd);
      check($sformatf("run_ch%0d", k), rd, exp_ch[k]);
    end

    // read-advance after a fresh reset
    apply_reset();
    bus_write(4'd0, 32'h2);
    bus_read(4'd2, rd); check("rdadv_first", rd, 32'hACE1_ACE1);
    bus_read(4'd2, rd); check("rdadv_second", rd, 32'hF570_D670);
    check("rdadv_ch1_port", port_ch(1), 32'hACE1_ACE2);
    bus_read(4'd1, rd); check("rdadv_count", rd, 32'h0);

    // write and read together: write wins, no advance
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; read_n = 1'b0;
    address = 4'd5; writedata = 32'h1234_5678;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1; read_n = 1'b1;
    check("wr_rd_ch3", port_ch(3), 32'h1234_5678);

    // seed write during RUN, then the next cycle steps
    bus_write(4'd0, 32'h1);
    bus_write(4'd2, 32'h0000_0010);
    check("run_seed_hold", port_ch(0), 32'h0000_0010);
    @(posedge clk);
    #1;
    check("run_seed_step", port_ch(0), 32'h0000_0008);

    // asynchronous reset mid-RUN
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("areset_ch0", port_ch(0), 32'hACE1_ACE1);
    check("areset_ch3", port_ch(3), 32'hACE1_ACE4);
    address = 4'd0;
    #1 check("areset_ctrl", readdata, 32'h0);
    address = 4'd1;
    #1 check("areset_count", readdata, 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("post_reset_idle", port_ch(0), 32'hACE1_ACE1);
    bus_write(4'd1, 32'h0);
    check("post_reset_step", port_ch(0), 32'hF570_D670);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/final_project_platform_rng_bank.md
# final_project_platform_rng_bank

Parametrised Avalon-MM slave holding NUM_CH independent Galois LFSR random-number channels of DATA_W bits each, replacing the software-written random-number PIO. The Nios II software seeds, steps or free-runs the channels over the bus. All channel states are exported on out_port so game logic (meteorite spawn/position) reads fresh values without bus traffic. Zero-wait-state reads, single clock domain.

## Interface
- DATA_W, 32, channel and bus data width (8..32)
- NUM_CH, 4, number of LFSR channels (1..14)
- ADDR_W, 4, address width; must satisfy 2^ADDR_W >= NUM_CH+2
- TAPS, 32'hA300_0000, right-shift Galois feedback mask (x^32+x^30+x^26+x^25+1), low DATA_W bits used
- SEED_BASE, 32'hACE1_ACE1, reset seed base
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- address  in  ADDR_W  word address
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- read_n  in  1  active-low read strobe
- writedata  in  DATA_W  write data
- readdata  out  DATA_W  read data, combinational from current registers
- out_port  out  NUM_CH*DATA_W  channel k state at bits [k*DATA_W +: DATA_W]

## Operation
- Register map: 0 CTRL; 1 STEP/COUNT; 2+k channel k (k < NUM_CH); other addresses read 0, writes ignored.
- CTRL bits: [0] RUN (all channels step every cycle); [1] RD_ADV (read of channel k steps channel k); [2] CLR (write-only, clears COUNT; reads 0). Reset 0.
- STEP write (any data): all channels step once. COUNT read: number of global step cycles (RUN cycles + STEP writes) since reset/clear, wraps at 2^DATA_W.
- Channel write: state <= writedata; writedata == 0 loads 1 (all-zero state forbidden).
- Step function: lsb = s[0]; s' = (s >> 1) ^ (lsb ? TAPS : 0).
- Reset: channel k = SEED_BASE + k (truncated to DATA_W; 0 replaced by 1); CTRL 0; COUNT 0; readdata reflects address combinationally.
- A channel steps at most once per cycle: step = RUN | STEP write | (RD_ADV & read of that channel).
- Priority per channel: seed write > step. Write and read both asserted: write wins, read-advance suppressed.
- Global step cycle with CLR in same cycle: COUNT = 0.
- Invalid-address accesses have no side effects.

## Timing
- Read latency 0: readdata valid in the cycle chipselect & ~read_n; returns pre-step value; state steps at that clock edge.
- Writes take effect at the rising edge of the access cycle; out_port updates same edge.
- RUN: out_port changes every cycle; bus reads return current value.
- Reset asserted mid-run: all state to reset values immediately, asynchronously; first step after release uses reset seeds.

## Structure
- Package rng_bank_pkg: register offsets (CTRL, STEP, CH_BASE), CTRL bit indices, default TAPS and SEED_BASE.
- Sub-module rng_lfsr_channel: one DATA_W state register with load/step inputs, zero-seed fix, step function; generated NUM_CH times.
- Top: address decode, CTRL, COUNT, read mux, out_port concatenation.

## Test plan
- Reset release -> ch0 reads 0xACE1ACE1, ch1 0xACE1ACE2, CTRL 0, COUNT 0, out_port matches.
- STEP write -> ch0 = 0xF570D670, ch1 = 0x5670D671, COUNT = 1.
- Write 0 to ch2 -> reads 1; STEP -> ch2 = 0xA3000000.
- CTRL=1 for exactly 10 cycles then CTRL=0 -> COUNT = 10, each channel equals reference model stepped 10 times.
- CTRL=2 after reset: read ch0 -> 0xACE1ACE1, next read -> 0xF570D670; ch1 unchanged 0xACE1ACE2; COUNT stays 0.
- Seed write to ch0 during RUN -> ch0 holds written value that cycle, steps next cycle; reset asserted mid-RUN -> all registers return to reset values immediately.
